// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared VGA timing constants and sprite fetch state encoding
package vga_pkg;

    localparam logic [9:0] H_ACTIVE = 10'd640;
    localparam logic [9:0] V_ACTIVE = 10'd480;
    localparam logic [9:0] V_TOTAL  = 10'd525;
    localparam logic [9:0] V_LAST   = V_TOTAL - 10'd1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ADDR    = 2'd1,
        CAPTURE = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/sprite_row_shifter.sv
// rtl/sprite_row_shifter.sv - serialises one sprite row MSB-first with pixel replication
module sprite_row_shifter
    import vga_pkg::*;
#(
    parameter int SPRITE_W = 16,
    parameter int SCALE    = 1
) (
    input  logic                Clk,
    input  logic                Reset_n,
    input  logic                pixel_ce,
    input  logic [9:0]          DrawX,
    input  logic [9:0]          start_x,
    input  logic                row_valid,
    input  logic [SPRITE_W-1:0] row_data,
    output logic                pixel_on
);

    localparam int BIT_W = $clog2(SPRITE_W);
    localparam int REP_W = (SCALE > 1) ? $clog2(SCALE) : 1;
    localparam logic [BIT_W-1:0] BIT_MAX = BIT_W'(SPRITE_W - 1);
    localparam logic [REP_W-1:0] REP_MAX = REP_W'(SCALE - 1);

    logic [SPRITE_W-1:0] shifter;
    logic [BIT_W-1:0]    bit_cnt;
    logic [REP_W-1:0]    rep_cnt;

    // pixel_on always mirrors shifter's MSB while a row is in flight
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            pixel_on <= 1'b0;
            shifter  <= '0;
            bit_cnt  <= '0;
            rep_cnt  <= '0;
        end else if (pixel_ce) begin
            if (DrawX >= H_ACTIVE) begin
                pixel_on <= 1'b0;
                bit_cnt  <= '0;
            end else if (row_valid && (DrawX == start_x)) begin
                pixel_on <= row_data[SPRITE_W-1];
                shifter  <= row_data;
                bit_cnt  <= BIT_MAX;
                rep_cnt  <= REP_MAX;
            end else if ((bit_cnt != '0) || (rep_cnt != '0)) begin
                if (rep_cnt != '0) begin
                    rep_cnt  <= rep_cnt - REP_W'(1);
                    pixel_on <= shifter[SPRITE_W-1];
                end else begin
                    shifter  <= {shifter[SPRITE_W-2:0], 1'b0};
                    pixel_on <= shifter[SPRITE_W-2];
                    bit_cnt  <= bit_cnt - BIT_W'(1);
                    rep_cnt  <= REP_MAX;
                end
            end else begin
                pixel_on <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/ship_sprite_reader.sv
// rtl/ship_sprite_reader.sv - fetches ship sprite rows in hblank and drives ship_on per pixel
module ship_sprite_reader
    import vga_pkg::*;
#(
    parameter int SPRITE_W = 16,
    parameter int SPRITE_H = 8,
    parameter int SCALE    = 1
) (
    input  logic                Clk,
    input  logic                Reset_n,
    input  logic                pixel_ce,
    input  logic [9:0]          DrawX,
    input  logic [9:0]          DrawY,
    input  logic [9:0]          ShipX,
    input  logic [9:0]          ShipY,
    output logic [7:0]          rom_addr,
    input  logic [SPRITE_W-1:0] rom_data,
    output logic                ship_on
);

    localparam int          SHIFT = $clog2(SCALE);
    localparam logic [10:0] SPAN  = 11'(SPRITE_H * SCALE);

    fetch_state_t        state;
    logic [9:0]          ship_x_l;
    logic [9:0]          ship_y_l;
    logic [SPRITE_W-1:0] row_reg;
    logic                row_valid;
    logic [9:0]          next_line;
    logic [10:0]         row_off;
    logic                row_hit;
    logic                hblank_start;
    logic                frame_latch;

    always_comb begin
        next_line    = (DrawY == V_LAST) ? 10'd0 : DrawY + 10'd1;
        row_off      = {1'b0, next_line} - {1'b0, ship_y_l};
        row_hit      = (next_line >= ship_y_l) && (row_off < SPAN);
        hblank_start = pixel_ce && (DrawX == H_ACTIVE);
        frame_latch  = hblank_start && (DrawY == V_ACTIVE);
    end

    // Position is frozen for the whole frame so a moving ship never tears
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            ship_x_l <= '0;
            ship_y_l <= '0;
        end else if (frame_latch) begin
            ship_x_l <= ShipX;
            ship_y_l <= ShipY;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state     <= IDLE;
            rom_addr  <= '0;
            row_reg   <= '0;
            row_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (hblank_start) begin
                        if (row_hit) begin
                            rom_addr <= 8'(row_off >> SHIFT);
                            state    <= ADDR;
                        end else begin
                            row_valid <= 1'b0;
                        end
                    end
                end
                ADDR: begin
                    state <= CAPTURE;
                end
                CAPTURE: begin
                    row_reg   <= rom_data;
                    row_valid <= 1'b1;
                    state     <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    sprite_row_shifter #(
        .SPRITE_W (SPRITE_W),
        .SCALE    (SCALE)
    ) u_shifter (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .pixel_ce  (pixel_ce),
        .DrawX     (DrawX),
        .start_x   (ship_x_l),
        .row_valid (row_valid),
        .row_data  (row_reg),
        .pixel_on  (ship_on)
    );

endmodule

// File: tb/tb_ship_sprite_reader.sv
// tb/tb_ship_sprite_reader.sv - self-checking bench for ship_sprite_reader at SCALE 1 and 2
module tb_ship_sprite_reader;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic        pixel_ce;
    logic [9:0]  DrawX, DrawY, ShipX, ShipY;
    logic [7:0]  rom_addr1, rom_addr2;
    logic [15:0] rom_data1, rom_data2;
    logic        ship_on1, ship_on2;
    logic [15:0] rom_mem [0:255];

    always #5 Clk = ~Clk;

    assign rom_data1 = rom_mem[rom_addr1];
    assign rom_data2 = rom_mem[rom_addr2];

    ship_sprite_reader #(.SPRITE_W(16), .SPRITE_H(8), .SCALE(1)) dut1 (
        .Clk(Clk), .Reset_n(Reset_n), .pixel_ce(pixel_ce), .DrawX(DrawX), .DrawY(DrawY),
        .ShipX(ShipX), .ShipY(ShipY), .rom_addr(rom_addr1), .rom_data(rom_data1), .ship_on(ship_on1)
    );

    ship_sprite_reader #(.SPRITE_W(16), .SPRITE_H(8), .SCALE(2)) dut2 (
        .Clk(Clk), .Reset_n(Reset_n), .pixel_ce(pixel_ce), .DrawX(DrawX), .DrawY(DrawY),
        .ShipX(ShipX), .ShipY(ShipY), .rom_addr(rom_addr2), .rom_data(rom_data2), .ship_on(ship_on2)
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    bit          chk_en = 1'b0;
    logic        exp_on [2];
    logic [7:0]  exp_addr [2];
    int          m_sx [2];
    int          m_sy [2];
    bit          m_valid [2];
    logic [15:0] m_row [2];
    logic        got1 [0:700];
    logic        got2 [0:700];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void model_reset();
        for (int k = 0; k < 2; k++) begin
            m_sx[k] = 0; m_sy[k] = 0; m_valid[k] = 1'b0; m_row[k] = '0;
            exp_on[k] = 1'b0; exp_addr[k] = '0;
        end
    endfunction

    // Sprite covers SPRITE_W*s pixels from the latched X; each ROM bit repeats s times
    function automatic void model_step(input int x, input int y);
        for (int k = 0; k < 2; k++) begin
            int s;
            int off;
            s   = (k == 0) ? 1 : 2;
            off = x - m_sx[k];
            exp_on[k] = (x < 640 && m_valid[k] && off >= 0 && off < 16 * s) ?
                        m_row[k][15 - off / s] : 1'b0;
            if (x == 640) begin
                int nl;
                int d;
                nl = (y == 524) ? 0 : y + 1;
                d  = nl - m_sy[k];
                if (d >= 0 && d < 8 * s) begin
                    exp_addr[k] = 8'(d / s);
                    m_row[k]    = rom_mem[d / s];
                    m_valid[k]  = 1'b1;
                end else begin
                    m_valid[k] = 1'b0;
                end
            end
        end
        if (x == 640 && y == 480) begin
            for (int k = 0; k < 2; k++) begin
                m_sx[k] = int'(ShipX);
                m_sy[k] = int'(ShipY);
            end
        end
    endfunction

    always @(posedge Clk) begin
        #1;
        if (chk_en) begin
            check("ship_on s1", {15'd0, ship_on1}, {15'd0, exp_on[0]});
            check("ship_on s2", {15'd0, ship_on2}, {15'd0, exp_on[1]});
            check("rom_addr s1", {8'd0, rom_addr1}, {8'd0, exp_addr[0]});
            check("rom_addr s2", {8'd0, rom_addr2}, {8'd0, exp_addr[1]});
        end
    end

    task automatic pix(input int x, input int y);
        @(negedge Clk);
        DrawX = 10'(x); DrawY = 10'(y); pixel_ce = 1'b1;
        model_step(x, y);
        @(negedge Clk);
        pixel_ce = 1'b0;
    endtask

    task automatic trigger(input int y);
        pix(640, y);
        repeat (3) @(negedge Clk);
    endtask

    task automatic sweep(input int y, input int x_last);
        for (int x = 0; x <= x_last; x++) begin
            pix(x, y);
            got1[x] = ship_on1;
            got2[x] = ship_on2;
        end
    endtask

    function automatic int ones(input int which, input int a, input int b);
        int n;
        n = 0;
        for (int x = a; x <= b; x++) n += (which == 1) ? int'(got1[x]) : int'(got2[x]);
        return n;
    endfunction

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 256; i++) rom_mem[i] = 16'h0000;
        rom_mem[0] = 16'h7FFE; rom_mem[1] = 16'hA5A5; rom_mem[2] = 16'h03C0;
        rom_mem[3] = 16'hFFFF; rom_mem[4] = 16'h8001; rom_mem[5] = 16'h1234;
        rom_mem[6] = 16'h0FF0; rom_mem[7] = 16'hC003;
        Reset_n = 1'b0; pixel_ce = 1'b0; DrawX = '0; DrawY = '0; ShipX = '0; ShipY = '0;
        model_reset();
        repeat (3) @(negedge Clk);
        check("reset ship_on s1", {15'd0, ship_on1}, 16'd0);
        check("reset rom_addr s1", {8'd0, rom_addr1}, 16'd0);
        check("reset ship_on s2", {15'd0, ship_on2}, 16'd0);
        check("reset rom_addr s2", {8'd0, rom_addr2}, 16'd0);
        Reset_n = 1'b1;
        chk_en  = 1'b1;

        ShipX = 10'd100; ShipY = 10'd200;
        pix(640, 480);
        trigger(199);
        check("line199 rom_addr", {8'd0, rom_addr1}, 16'd0);
        sweep(200, 660);
        check("row0 x100", {15'd0, got1[100]}, 16'd0);
        check("row0 x101", {15'd0, got1[101]}, 16'd1);
        check("row0 x114", {15'd0, got1[114]}, 16'd1);
        check("row0 x115", {15'd0, got1[115]}, 16'd0);
        check("row0 x116", {15'd0, got1[116]}, 16'd0);
        check("row0 count", 16'(ones(1, 0, 660)), 16'd14);

        trigger(201);
        check("line201 rom_addr", {8'd0, rom_addr1}, 16'd2);
        sweep(202, 660);
        check("row2 x105", {15'd0, got1[105]}, 16'd0);
        check("row2 x106", {15'd0, got1[106]}, 16'd1);
        check("row2 x109", {15'd0, got1[109]}, 16'd1);
        check("row2 x110", {15'd0, got1[110]}, 16'd0);
        check("row2 count", 16'(ones(1, 0, 660)), 16'd4);

        trigger(207);
        sweep(208, 660);
        check("line208 count", 16'(ones(1, 0, 660)), 16'd0);

        ShipX = 10'd300;
        pix(5, 250);
        trigger(201);
        sweep(202, 660);
        check("midframe old x106", {15'd0, got1[106]}, 16'd1);
        check("midframe old x306", {15'd0, got1[306]}, 16'd0);
        pix(640, 480);
        trigger(201);
        sweep(202, 660);
        check("nextframe x106", {15'd0, got1[106]}, 16'd0);
        check("nextframe x306", {15'd0, got1[306]}, 16'd1);

        ShipX = 10'd630; ShipY = 10'd300;
        pix(640, 480);
        trigger(302);
        sweep(303, 700);
        check("clip x630", {15'd0, got1[630]}, 16'd1);
        check("clip x639", {15'd0, got1[639]}, 16'd1);
        check("clip x640", {15'd0, got1[640]}, 16'd0);
        check("clip beyond", 16'(ones(1, 640, 700)), 16'd0);
        check("clip count", 16'(ones(1, 0, 700)), 16'd10);

        ShipX = 10'd10; ShipY = 10'd0;
        pix(640, 480);
        trigger(524);
        check("wrap rom_addr s2", {8'd0, rom_addr2}, 16'd0);
        for (int ln = 0; ln < 2; ln++) begin
            sweep(ln, 660);
            check("s2 x10", {15'd0, got2[10]}, 16'd0);
            check("s2 x11", {15'd0, got2[11]}, 16'd0);
            check("s2 x12", {15'd0, got2[12]}, 16'd1);
            check("s2 x39", {15'd0, got2[39]}, 16'd1);
            check("s2 x40", {15'd0, got2[40]}, 16'd0);
            check("s2 count", 16'(ones(2, 0, 660)), 16'd28);
        end

        ShipX = 10'd100; ShipY = 10'd200;
        pix(640, 480);
        trigger(201);
        sweep(202, 108);
        check("pre-reset x108", {15'd0, got1[108]}, 16'd1);
        #2;
        Reset_n = 1'b0;
        model_reset();
        #1;
        check("async reset ship_on s1", {15'd0, ship_on1}, 16'd0);
        check("async reset rom_addr s1", {8'd0, rom_addr1}, 16'd0);
        check("async reset rom_addr s2", {8'd0, rom_addr2}, 16'd0);
        repeat (2) @(negedge Clk);
        Reset_n = 1'b1;
        trigger(200);
        sweep(201, 660);
        check("post-reset dark s1", 16'(ones(1, 0, 660)), 16'd0);
        check("post-reset dark s2", 16'(ones(2, 0, 660)), 16'd0);
        pix(640, 480);
        trigger(200);
        sweep(201, 660);
        check("restored x100", {15'd0, got1[100]}, 16'd1);
        check("restored x101", {15'd0, got1[101]}, 16'd0);
        check("restored x102", {15'd0, got1[102]}, 16'd1);

        chk_en = 1'b0;
        @(negedge Clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
